rf_wb_sched: RTL and testbench

RF_WB_SCHED -- requirements
Module: rf_wb_sched

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 55 +++++
 rtl/rf_wb_sched.sv | 129 ++++++++++++
 tb/tb_rf_wb_sched.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the writeback scheduler: register-file geometry,
// default widths/limits and the writeback requester encoding.
package rf_pkg;

   localparam int REG_AW           = 5;
   localparam int NUM_REGS         = 32;
   localparam int XLEN_DEF         = 32;
   localparam int STARVE_LIMIT_DEF = 3;

   typedef enum logic [1:0] {
      REQ_NONE,
      REQ_ALU,
      REQ_LSU
   } req_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Register busy scoreboard. A register is marked busy when an instruction that
// writes it issues, and is released when its writeback lands on the register
// file. A writeback happening in the current cycle already counts as resolved,
// because the register file writes on the falling edge before operands are read.
module rf_scoreboard
   import rf_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en,
   input  logic [REG_AW-1:0] set_idx,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_idx,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic [REG_AW-1:0] rd,
   output logic              hit_any
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic                hit_rs1;
   logic                hit_rs2;
   logic                hit_rd;

   // Next busy vector: clear the retiring register, then set the newly issued one so a same-index set wins; x0 is never busy.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) begin
         busy_d[clr_idx] = 1'b0;
      end
      if (set_en) begin
         busy_d[set_idx] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Busy vector register, emptied by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // A register hits when busy and not being written back in this same cycle.
   always_comb begin
      hit_rs1 = busy_q[rs1] && !(clr_en && (clr_idx == rs1));
      hit_rs2 = busy_q[rs2] && !(clr_en && (clr_idx == rs2));
      hit_rd  = busy_q[rd]  && !(clr_en && (clr_idx == rd));
      hit_any = hit_rs1 || hit_rs2 || hit_rd;
   end

endmodule

// File: rtl/rf_wb_sched.sv
// Writeback scheduler: arbitrates ALU and load-unit writebacks onto the single
// register-file write port (LSU preferred, ALU promoted after repeated losses),
// registers the winning write for one cycle, and stalls issue on RAW/WAW hazards
// tracked by the scoreboard.
module rf_wb_sched
   import rf_pkg::*;
#(
   parameter int XLEN         = XLEN_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rs1,
   input  logic [REG_AW-1:0] iss_rs2,
   input  logic [REG_AW-1:0] iss_rd,
   output logic              iss_stall,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   output logic              alu_ready,
   input  logic              lsu_valid,
   input  logic [REG_AW-1:0] lsu_rd,
   input  logic [XLEN-1:0]   lsu_data,
   output logic              lsu_ready,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_wa,
   output logic [XLEN-1:0]   rf_wd
);

   req_e              grant;
   logic              alu_first;
   logic [1:0]        starve_q;
   logic [1:0]        starve_d;
   logic              rf_we_q;
   logic              rf_we_d;
   logic [REG_AW-1:0] rf_wa_q;
   logic [REG_AW-1:0] rf_wa_d;
   logic [XLEN-1:0]   rf_wd_q;
   logic [XLEN-1:0]   rf_wd_d;
   logic              hit_any;
   logic              iss_accept;
   logic              sb_set_en;

   // Pick the writeback winner: LSU by default, ALU once it has lost STARVE_LIMIT times in a row; nobody while in reset.
   always_comb begin
      grant     = REQ_NONE;
      alu_first = alu_valid && (int'(starve_q) == STARVE_LIMIT);
      if (!rst) begin
         if (lsu_valid && !alu_first) begin
            grant = REQ_LSU;
         end else if (alu_valid) begin
            grant = REQ_ALU;
         end
      end
      alu_ready = (grant == REQ_ALU);
      lsu_ready = (grant == REQ_LSU);
   end

   // Count consecutive cycles the ALU waited without a grant, saturating at the counter's top value.
   always_comb begin
      starve_d = 2'd0;
      if (alu_valid && (grant != REQ_ALU)) begin
         starve_d = (starve_q == 2'd3) ? starve_q : starve_q + 2'd1;
      end
   end

   // Capture the granted request for the write port; writes to x0 are consumed without a write strobe.
   always_comb begin
      rf_we_d = 1'b0;
      rf_wa_d = rf_wa_q;
      rf_wd_d = rf_wd_q;
      case (grant)
         REQ_ALU: begin
            rf_we_d = (alu_rd != '0);
            rf_wa_d = alu_rd;
            rf_wd_d = alu_data;
         end
         REQ_LSU: begin
            rf_we_d = (lsu_rd != '0);
            rf_wa_d = lsu_rd;
            rf_wd_d = lsu_data;
         end
         default: begin
            rf_we_d = 1'b0;
         end
      endcase
   end

   // Arbitration state and the registered write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= 2'd0;
         rf_we_q  <= 1'b0;
         rf_wa_q  <= '0;
         rf_wd_q  <= '0;
      end else begin
         starve_q <= starve_d;
         rf_we_q  <= rf_we_d;
         rf_wa_q  <= rf_wa_d;
         rf_wd_q  <= rf_wd_d;
      end
   end

   // Issue handshake: stall on any hazard hit, accept otherwise, and mark the destination busy.
   always_comb begin
      iss_stall  = iss_valid && hit_any && !rst;
      iss_accept = iss_valid && !hit_any && !rst;
      sb_set_en  = iss_accept && (iss_rd != '0);
   end

   rf_scoreboard u_scoreboard (
      .clk     (clk),
      .rst     (rst),
      .set_en  (sb_set_en),
      .set_idx (iss_rd),
      .clr_en  (rf_we_q),
      .clr_idx (rf_wa_q),
      .rs1     (iss_rs1),
      .rs2     (iss_rs2),
      .rd      (iss_rd),
      .hit_any (hit_any)
   );

   assign rf_we = rf_we_q;
   assign rf_wa = rf_wa_q;
   assign rf_wd = rf_wd_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Bench for rf_wb_sched: directed hazard/arbitration/reset scenarios with
// hand-computed expectations, then randomized traffic, all shadowed by a
// behavioural model checked every cycle on the falling edge.
module tb_rf_wb_sched;

   localparam int XLEN         = 32;
   localparam int STARVE_LIMIT = 3;

   logic              clk;
   logic              rst;
   logic              iss_valid;
   logic [4:0]        iss_rs1;
   logic [4:0]        iss_rs2;
   logic [4:0]        iss_rd;
   logic              iss_stall;
   logic              alu_valid;
   logic [4:0]        alu_rd;
   logic [XLEN-1:0]   alu_data;
   logic              alu_ready;
   logic              lsu_valid;
   logic [4:0]        lsu_rd;
   logic [XLEN-1:0]   lsu_data;
   logic              lsu_ready;
   logic              rf_we;
   logic [4:0]        rf_wa;
   logic [XLEN-1:0]   rf_wd;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: which registers await a writeback, how many times the ALU
   // has lost in a row, and the write that should appear on the port now.
   bit              m_busy [32];
   int              m_starve;
   bit              m_we;
   int              m_wa;
   logic [XLEN-1:0] m_wd;

   rf_wb_sched #(
      .XLEN         (XLEN),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .iss_rd    (iss_rd),
      .iss_stall (iss_stall),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .lsu_valid (lsu_valid),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .lsu_ready (lsu_ready),
      .rf_we     (rf_we),
      .rf_wa     (rf_wa),
      .rf_wd     (rf_wd)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the run never reaches its summary.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit iv, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input bit av, input logic [4:0] ard,
                                input logic [XLEN-1:0] ad, input bit lv, input logic [4:0] lrd,
                                input logic [XLEN-1:0] ld);
      iss_valid = iv;
      iss_rs1   = rs1;
      iss_rs2   = rs2;
      iss_rd    = rd;
      alu_valid = av;
      alu_rd    = ard;
      alu_data  = ad;
      lsu_valid = lv;
      lsu_rd    = lrd;
      lsu_data  = ld;
   endtask

   task automatic toDrive();
      @(posedge clk);
      #1;
   endtask

   function automatic bit modelHit(input logic [4:0] r);
      return (r != 5'd0) && m_busy[r] && !(m_we && (m_wa == int'(r)));
   endfunction

   // Every falling edge: compare the DUT against the model, then advance the model by one clock.
   always @(negedge clk) begin
      bit alu_pref;
      bit exp_alu;
      bit exp_lsu;
      bit exp_stall;
      if (rst) begin
         checkOutput("rst_alu_ready", alu_ready, 0);
         checkOutput("rst_lsu_ready", lsu_ready, 0);
         checkOutput("rst_iss_stall", iss_stall, 0);
         checkOutput("rst_rf_we", rf_we, 0);
         checkOutput("rst_rf_wa", rf_wa, 0);
         checkOutput("rst_rf_wd", rf_wd, 0);
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_starve = 0;
         m_we     = 1'b0;
         m_wa     = 0;
         m_wd     = '0;
      end else begin
         alu_pref  = alu_valid && (m_starve >= STARVE_LIMIT);
         exp_lsu   = lsu_valid && !alu_pref;
         exp_alu   = alu_valid && !exp_lsu;
         exp_stall = iss_valid && (modelHit(iss_rs1) || modelHit(iss_rs2) || modelHit(iss_rd));
         checkOutput("model_alu_ready", alu_ready, exp_alu);
         checkOutput("model_lsu_ready", lsu_ready, exp_lsu);
         checkOutput("model_ready_exclusive", alu_ready & lsu_ready, 0);
         checkOutput("model_iss_stall", iss_stall, exp_stall);
         checkOutput("model_rf_we", rf_we, m_we);
         if (m_we) begin
            checkOutput("model_rf_wa", rf_wa, m_wa);
            checkOutput("model_rf_wd", rf_wd, m_wd);
         end
         if (m_we) m_busy[m_wa] = 1'b0;
         if (iss_valid && !exp_stall && (iss_rd != 5'd0)) m_busy[iss_rd] = 1'b1;
         if (alu_valid && !exp_alu) m_starve = (m_starve >= 3) ? 3 : m_starve + 1;
         else m_starve = 0;
         if (exp_alu) begin
            m_we = (alu_rd != 5'd0);
            m_wa = int'(alu_rd);
            m_wd = alu_data;
         end else if (exp_lsu) begin
            m_we = (lsu_rd != 5'd0);
            m_wa = int'(lsu_rd);
            m_wd = lsu_data;
         end else begin
            m_we = 1'b0;
         end
      end
   end

   // Directed scenarios with literal expectations, then randomized traffic.
   initial begin
      int pat [6];
      bit alu_acc;
      bit lsu_acc;
      pat = '{1, 1, 1, 0, 1, 1};

      rst = 1'b1;
      applyStimulus(1, 5'd1, 5'd2, 5'd3, 1, 5'd4, 32'h1, 1, 5'd5, 32'h2);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_rf_we", rf_we, 0);
      checkOutput("reset_rf_wa", rf_wa, 0);
      checkOutput("reset_rf_wd", rf_wd, 0);
      checkOutput("reset_alu_ready", alu_ready, 0);
      checkOutput("reset_lsu_ready", lsu_ready, 0);
      checkOutput("reset_iss_stall", iss_stall, 0);
      toDrive();
      rst = 1'b0;

      // RAW hazard on x5 held until the ALU writes it back.
      applyStimulus(1, 5'd0, 5'd0, 5'd5, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      checkOutput("raw_issue_rd5", iss_stall, 0);
      toDrive();
      applyStimulus(1, 5'd5, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      checkOutput("raw_stall", iss_stall, 1);
      toDrive();
      applyStimulus(1, 5'd5, 5'd0, 5'd0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
      @(negedge clk);
      checkOutput("raw_alu_ready", alu_ready, 1);
      checkOutput("raw_stall_pre_wb", iss_stall, 1);
      toDrive();
      applyStimulus(1, 5'd5, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      checkOutput("raw_wb_we", rf_we, 1);
      checkOutput("raw_wb_wa", rf_wa, 5);
      checkOutput("raw_wb_wd", rf_wd, 32'hDEADBEEF);
      checkOutput("raw_stall_released", iss_stall, 0);
      toDrive();

      // Both requesters busy: starvation promotes the ALU on the fourth cycle.
      for (int k = 0; k < 6; k++) begin
         applyStimulus(0, 5'd0, 5'd0, 5'd0, 1, 5'd3, 32'hA0000003, 1, 5'd4, 32'hB0000004);
         @(negedge clk);
         checkOutput("arb_lsu_ready", lsu_ready, pat[k]);
         checkOutput("arb_alu_ready", alu_ready, 1 - pat[k]);
         if (k > 0) checkOutput("arb_rf_wa", rf_wa, (pat[k-1] == 1) ? 4 : 3);
         toDrive();
      end
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      checkOutput("arb_last_we", rf_we, 1);
      checkOutput("arb_last_wa", rf_wa, 4);
      toDrive();

      // Write to x0 is consumed but never strobes the register file.
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h1234);
      @(negedge clk);
      checkOutput("x0_lsu_ready", lsu_ready, 1);
      toDrive();
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      checkOutput("x0_no_we", rf_we, 0);
      toDrive();

      // Same-cycle retire and re-issue of x7 keeps it busy.
      applyStimulus(1, 5'd0, 5'd0, 5'd7, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      checkOutput("waw_issue_rd7", iss_stall, 0);
      toDrive();
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 1, 5'd7, 32'h77, 0, 5'd0, 32'h0);
      @(negedge clk);
      checkOutput("waw_alu_ready", alu_ready, 1);
      toDrive();
      applyStimulus(1, 5'd0, 5'd0, 5'd7, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      checkOutput("waw_wb_we", rf_we, 1);
      checkOutput("waw_wb_wa", rf_wa, 7);
      checkOutput("waw_reissue_stall", iss_stall, 0);
      toDrive();
      applyStimulus(1, 5'd0, 5'd7, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      checkOutput("waw_busy_kept", iss_stall, 1);
      toDrive();
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 1, 5'd7, 32'h78, 0, 5'd0, 32'h0);
      @(negedge clk);
      toDrive();
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      toDrive();

      // Reset mid-stream drops the pending write and every busy bit.
      applyStimulus(1, 5'd0, 5'd0, 5'd2, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      checkOutput("rst_mid_issue_rd2", iss_stall, 0);
      toDrive();
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h99);
      @(negedge clk);
      checkOutput("rst_mid_lsu_ready", lsu_ready, 1);
      toDrive();
      checkOutput("rst_mid_pending_we", rf_we, 1);
      rst = 1'b1;
      applyStimulus(1, 5'd2, 5'd0, 5'd0, 1, 5'd1, 32'h5, 1, 5'd1, 32'h6);
      #1;
      checkOutput("rst_mid_we_drop", rf_we, 0);
      @(negedge clk);
      checkOutput("rst_mid_alu_ready", alu_ready, 0);
      checkOutput("rst_mid_lsu_ready_low", lsu_ready, 0);
      checkOutput("rst_mid_stall_low", iss_stall, 0);
      toDrive();
      rst = 1'b0;
      applyStimulus(1, 5'd2, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      checkOutput("rst_mid_no_stale_busy", iss_stall, 0);
      toDrive();

      // Random traffic; a requester keeps its request steady until it is accepted.
      alu_acc = 1'b1;
      lsu_acc = 1'b1;
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      for (int i = 0; i < 3000; i++) begin
         if (!(alu_valid && !alu_acc)) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
         end
         if (!(lsu_valid && !lsu_acc)) begin
            lsu_valid = ($urandom_range(0, 99) < 50);
            lsu_rd    = 5'($urandom_range(0, 7));
            lsu_data  = $urandom;
         end
         iss_valid = ($urandom_range(0, 99) < 60);
         iss_rs1   = 5'($urandom_range(0, 7));
         iss_rs2   = 5'($urandom_range(0, 7));
         iss_rd    = 5'($urandom_range(0, 7));
         @(negedge clk);
         alu_acc = alu_valid && alu_ready;
         lsu_acc = lsu_valid && lsu_ready;
         toDrive();
      end

      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      repeat (3) toDrive();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
